// File: rtl/timer_dev.sv
// -----------------------------------------------------------------------------
// timer_dev
//
// Memory-mapped down-counting timer with an interrupt request output, intended
// to sit on the processor bus next to the coprocessor's HWInt inputs.
//
// Register map (word offset on addr):
//   0 CTRL   : bit0 EN, bits2:1 MODE, bit3 IM; upper bits read as zero
//   1 PRESET : 32-bit reload value, read/write
//   2 COUNT  : 32-bit current count, read-only
//   3        : unused, reads zero, writes ignored
//
// MODE 1 is auto-reload; every other MODE value runs as one-shot.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high reset
//   addr   register select
//   we     register write strobe, sampled on the rising edge
//   din    write data
//   dout   combinational read data for the register selected by addr
//   irq    interrupt request, CTRL.IM & PEND, driven from flops only
// -----------------------------------------------------------------------------
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;
    localparam logic [1:0] MODE_RELOAD = 2'd1;

    state_t      state_q, state_d;

    logic        ctrl_en_q, ctrl_en_d;
    logic [1:0]  ctrl_mode_q, ctrl_mode_d;
    logic        ctrl_im_q, ctrl_im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        auto_reload;
    logic        count_is_zero;
    logic        count_le_one;

    logic        load_count;
    logic        dec_count;
    logic        set_pend;
    logic        auto_clear_en;
    logic        reload_clear_pend;

    // Bus write decode. Only CTRL and PRESET are writable; COUNT and the
    // unused slot simply have no decode, so writes there fall on the floor.
    always_comb begin
        wr_ctrl   = we && (addr == ADDR_CTRL);
        wr_preset = we && (addr == ADDR_PRESET);
    end

    // Status terms derived from the registered state. The FSM only ever looks
    // at flop outputs, which is why a bus write becomes visible to it one
    // cycle after the write edge.
    always_comb begin
        auto_reload   = (ctrl_mode_q == MODE_RELOAD);
        count_is_zero = (count_q == 32'd0);
        count_le_one  = (count_q <= 32'd1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic. CNT exits to INT both when the counter is about
    // to reach zero and when it was loaded with zero, so a zero PRESET still
    // produces one interrupt after a single CNT cycle. Clearing EN always
    // takes priority in CNT and leaves the count frozen where it is.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_en_q) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_en_q) begin
                    state_d = S_IDLE;
                end else if (count_le_one) begin
                    state_d = S_INT;
                end
            end
            S_INT: begin
                state_d = auto_reload ? S_LOAD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output decode: one-cycle action strobes for the datapath. The
    // decrement is suppressed at zero so the counter can never wrap.
    always_comb begin
        load_count        = 1'b0;
        dec_count         = 1'b0;
        set_pend          = 1'b0;
        auto_clear_en     = 1'b0;
        reload_clear_pend = 1'b0;
        case (state_q)
            S_LOAD: begin
                load_count = 1'b1;
            end
            S_CNT: begin
                if (ctrl_en_q) begin
                    dec_count = !count_is_zero;
                    set_pend  = count_le_one;
                end
            end
            S_INT: begin
                auto_clear_en     = !auto_reload;
                reload_clear_pend = auto_reload;
            end
            default: begin
            end
        endcase
    end

    // CTRL next value. The one-shot EN clear is applied first and a CTRL
    // write on the same edge is applied afterwards, so software re-arming the
    // timer during the INT cycle is not lost.
    always_comb begin
        ctrl_en_d   = ctrl_en_q;
        ctrl_mode_d = ctrl_mode_q;
        ctrl_im_d   = ctrl_im_q;
        if (auto_clear_en) begin
            ctrl_en_d = 1'b0;
        end
        if (wr_ctrl) begin
            ctrl_en_d   = din[0];
            ctrl_mode_d = din[2:1];
            ctrl_im_d   = din[3];
        end
    end

    // PRESET and COUNT next values. COUNT only picks up PRESET in LOAD, so a
    // PRESET rewrite while counting affects the next period, not this one.
    always_comb begin
        preset_d = preset_q;
        count_d  = count_q;
        if (wr_preset) begin
            preset_d = din;
        end
        if (load_count) begin
            count_d = preset_q;
        end else if (dec_count) begin
            count_d = count_q - 32'd1;
        end
    end

    // PEND next value. In auto-reload it is a one-cycle pulse cleared as the
    // FSM leaves INT; in one-shot it latches until software writes CTRL or
    // PRESET. The set is evaluated last so a new expiry on the same edge as
    // a clearing write is never dropped.
    always_comb begin
        pend_d = pend_q;
        if (reload_clear_pend) begin
            pend_d = 1'b0;
        end
        if ((wr_ctrl || wr_preset) && !auto_reload) begin
            pend_d = 1'b0;
        end
        if (set_pend) begin
            pend_d = 1'b1;
        end
    end

    // Register bank. Reset is checked first so it beats any bus write
    // presented on the same edge and aborts a running count with no irq.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en_q   <= 1'b0;
            ctrl_mode_q <= 2'd0;
            ctrl_im_q   <= 1'b0;
            preset_q    <= 32'd0;
            count_q     <= 32'd0;
            pend_q      <= 1'b0;
        end else begin
            ctrl_en_q   <= ctrl_en_d;
            ctrl_mode_q <= ctrl_mode_d;
            ctrl_im_q   <= ctrl_im_d;
            preset_q    <= preset_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
        end
    end

    // Combinational read mux.
    always_comb begin
        dout = 32'd0;
        case (addr)
            ADDR_CTRL:   dout = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
            ADDR_PRESET: dout = preset_q;
            ADDR_COUNT:  dout = count_q;
            default:     dout = 32'd0;
        endcase
    end

    // The interrupt line is built purely from flops, so there is no path from
    // din or we through to irq.
    assign irq = ctrl_im_q & pend_q;

endmodule

// File: tb/tb_timer_dev.sv
// -----------------------------------------------------------------------------
// tb_timer_dev
//
// Directed bench for timer_dev. The stimulus process issues bus writes and
// read requests; each read request pushes its hand-computed expected dout and
// irq into a scoreboard queue, and a separate monitor pops and compares on the
// falling edge while the request is presented.
// -----------------------------------------------------------------------------
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    logic        sample_req;
    logic [32:0] exp_q [$];
    string       name_q [$];

    int checks;
    int failures;

    int cnt34 [8]  = '{0, 0, 5, 4, 3, 2, 1, 0};
    bit irq34 [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};
    int cnt35 [12] = '{0, 0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
    bit irq35 [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int cnt38 [10] = '{5, 4, 3, 2, 1, 0, 0, 2, 1, 0};
    bit irq38 [10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

    timer_dev dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: whenever a read request is on the bus, pop the oldest expected
    // entry and compare dout and irq against it.
    always @(negedge clk) begin
        if (sample_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_underflow: read with no expected entry, dout=%h", dout);
            end else begin
                logic [32:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checks++;
                if (dout !== e[31:0]) begin
                    failures++;
                    $display("[TB] FAIL %s dout: actual=%h required=%h", n, dout, e[31:0]);
                end
                checks++;
                if (irq !== e[32]) begin
                    failures++;
                    $display("[TB] FAIL %s irq: actual=%b required=%b", n, irq, e[32]);
                end
            end
        end
    end

    // One bus write; returns #1 after the edge on which the write lands.
    task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    // One read request occupying a single cycle; the expected response goes
    // into the scoreboard for the monitor.
    task automatic checkOutput(input string n, input logic [1:0] a,
                               input logic [31:0] exp_dout, input logic exp_irq);
        addr = a;
        exp_q.push_back({exp_irq, exp_dout});
        name_q.push_back(n);
        sample_req = 1'b1;
        @(posedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        we         = 1'b0;
        addr       = 2'd0;
        din        = 32'd0;
        sample_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset_ctrl",   2'd0, 32'd0, 1'b0);
        checkOutput("reset_preset", 2'd1, 32'd0, 1'b0);
        checkOutput("reset_count",  2'd2, 32'd0, 1'b0);

        $display("[TB] register access");
        applyStimulus(2'd1, 32'hDEAD_BEEF);
        checkOutput("preset_rw", 2'd1, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(2'd2, 32'h0000_0055);
        applyStimulus(2'd3, 32'h0000_0077);
        checkOutput("count_readonly", 2'd2, 32'd0, 1'b0);
        checkOutput("addr3_zero",     2'd3, 32'd0, 1'b0);
        applyStimulus(2'd0, 32'hFFFF_FFF6);
        checkOutput("ctrl_upper_zero", 2'd0, 32'h0000_0006, 1'b0);
        applyStimulus(2'd0, 32'd0);

        $display("[TB] one-shot PRESET=5");
        applyStimulus(2'd1, 32'd5);
        applyStimulus(2'd0, 32'h9);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("oneshot_c%0d", i), 2'd2, cnt34[i], irq34[i]);
        end
        checkOutput("oneshot_en_cleared", 2'd0, 32'h8, 1'b1);
        checkOutput("oneshot_irq_held",   2'd2, 32'd0, 1'b1);
        applyStimulus(2'd0, 32'h8);
        checkOutput("oneshot_irq_cleared", 2'd0, 32'h8, 1'b0);

        $display("[TB] one-shot PRESET=0");
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd0, 32'h9);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("zero_c%0d", i), 2'd2, 32'd0, (i == 3));
        end
        checkOutput("zero_en_cleared", 2'd0, 32'h8, 1'b1);
        applyStimulus(2'd0, 32'h0);
        checkOutput("zero_irq_cleared", 2'd0, 32'h0, 1'b0);

        $display("[TB] expiry and PRESET write on the same edge");
        applyStimulus(2'd1, 32'd2);
        applyStimulus(2'd0, 32'h9);
        waitCycles(3);
        applyStimulus(2'd1, 32'd7);
        checkOutput("set_wins_count",  2'd2, 32'd0, 1'b1);
        checkOutput("set_wins_preset", 2'd1, 32'd7, 1'b1);
        applyStimulus(2'd0, 32'h0);
        checkOutput("set_wins_cleared", 2'd0, 32'h0, 1'b0);

        $display("[TB] CTRL write during INT");
        applyStimulus(2'd1, 32'd1);
        applyStimulus(2'd0, 32'h9);
        waitCycles(3);
        applyStimulus(2'd0, 32'h9);
        checkOutput("int_write_en_kept", 2'd0, 32'h9, 1'b0);
        checkOutput("int_write_load",    2'd2, 32'd0, 1'b0);
        checkOutput("int_write_cnt",     2'd2, 32'd1, 1'b0);
        checkOutput("int_write_expire",  2'd2, 32'd0, 1'b1);
        checkOutput("int_write_en_clr",  2'd0, 32'h8, 1'b1);
        applyStimulus(2'd0, 32'h0);
        checkOutput("int_write_cleared", 2'd0, 32'h0, 1'b0);

        $display("[TB] interrupt masked");
        applyStimulus(2'd1, 32'd2);
        applyStimulus(2'd0, 32'h1);
        waitCycles(4);
        checkOutput("masked_count", 2'd2, 32'd0, 1'b0);
        checkOutput("masked_ctrl",  2'd0, 32'h0, 1'b0);
        applyStimulus(2'd0, 32'h8);
        checkOutput("masked_unmask", 2'd0, 32'h8, 1'b0);
        applyStimulus(2'd0, 32'h0);

        $display("[TB] auto-reload PRESET=3");
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'hB);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("reload_c%0d", i), 2'd2, cnt35[i], irq35[i]);
        end
        checkOutput("reload_en_kept", 2'd0, 32'hB, 1'b0);
        applyStimulus(2'd0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("reload_frozen_%0d", i), 2'd2, 32'd1, 1'b0);
        end
        checkOutput("reload_stopped_ctrl", 2'd0, 32'h0, 1'b0);

        $display("[TB] PRESET rewrite while counting");
        applyStimulus(2'd1, 32'd10);
        applyStimulus(2'd0, 32'hB);
        waitCycles(6);
        applyStimulus(2'd1, 32'd2);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("rewrite_c%0d", i), 2'd2, cnt38[i], irq38[i]);
        end
        applyStimulus(2'd0, 32'h0);
        waitCycles(2);

        $display("[TB] reset mid-count");
        applyStimulus(2'd1, 32'd6);
        applyStimulus(2'd0, 32'hB);
        waitCycles(4);
        reset = 1'b1;
        checkOutput("pre_reset_count", 2'd2, 32'd4, 1'b0);
        reset = 1'b0;
        checkOutput("post_reset_ctrl",   2'd0, 32'd0, 1'b0);
        checkOutput("post_reset_preset", 2'd1, 32'd0, 1'b0);
        checkOutput("post_reset_count",  2'd2, 32'd0, 1'b0);

        addr  = 2'd0;
        din   = 32'hB;
        we    = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        reset = 1'b0;
        checkOutput("reset_beats_write", 2'd0, 32'd0, 1'b0);
        waitCycles(3);
        checkOutput("reset_beats_write_idle", 2'd2, 32'd0, 1'b0);

        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d entries left required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
